mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch requester and its load/store requester.
- Grants one request per cycle using data-priority arbitration with a starvation bound on fetch.
- Supports locked data sequences for read-modify-write store pairs.
- Tracks in-flight reads in a tag pipeline and routes each response back to its requester in order.

Parameters:
- RD_LATENCY, 1, memory read latency in cycles (legal 1..4); mem_rdata_i is valid RD_LATENCY cycles after the sampling edge.
- STARVE_MAX, 4, maximum number of consecutive data grants while i_req_i is pending before fetch is forced (legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_req_i  in  1  fetch request
- i_addr_i  in  32  fetch address
- i_gnt_o  out  1  fetch request accepted this cycle
- i_rvalid_o  out  1  fetch response valid
- i_rdata_o  out  32  fetch response data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write, 0 = read
- d_be_i  in  4  byte enables (writes)
- d_addr_i  in  32  data address
- d_wdata_i  in  32  write data
- d_lock_i  in  1  hold the port for the next data request
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response (read data or write ack)
- d_rdata_o  out  32  data response data (0 for write ack)
- mem_req_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data

Behaviour:
Reset:
- rst asserted: all outputs 0, tag pipeline cleared, starve_cnt=0, lock state cleared.
- Reset asserted mid-operation discards in-flight responses; no rvalid is produced for them after deassertion.

Handshake:
- A request is accepted in the cycle where req && gnt.
- Requester holds address/data stable until granted.
- gnt is combinational from req and arbiter state; it never asserts without req.

Arbitration, per cycle, at most one grant:
- LOCKED state: grant data only. If d_req_i=0, no grant occurs, fetch is still blocked, and the lock remains.
- Otherwise, if both requesting and starve_cnt==STARVE_MAX: grant fetch.
- Otherwise, if d_req_i: grant data.
- Otherwise, if i_req_i: grant fetch.

starve_cnt:
- Increments on a data grant while i_req_i=1.
- Clears on any fetch grant or when i_req_i=0.
- Saturates at STARVE_MAX.

Lock state machine, states UNLOCKED and LOCKED:
- UNLOCKED -> LOCKED on a data grant with d_lock_i=1.
- LOCKED -> UNLOCKED on a data grant with d_lock_i=0.
- Lock grants do not increment starve_cnt beyond saturation; the forced fetch waits until unlock.

Memory drive:
- mem_req_o = i_gnt_o | d_gnt_o.
- mem_* fields are muxed from the granted requester.
- Fetch grant drives mem_we_o=0 and mem_be_o=4'hF.
- No grant: mem_we_o=0, mem_be_o=0; addr/wdata are don't-care but driven 0.

Response routing:
- Shift-register tag pipeline of depth RD_LATENCY, with fields {valid, is_data, is_write}.
- A grant in cycle t yields a response in cycle t+RD_LATENCY.
- i_rvalid_o / d_rvalid_o are registered from the pipeline tail.
- rdata is mem_rdata_i passed combinationally when the matching rvalid is high, else 0.
- Write ack sets d_rdata_o=0.
- Responses are returned strictly in grant order; back-to-back grants produce back-to-back responses.
- No backpressure on responses: requesters must accept rvalid unconditionally.

Boundary conditions:
- Simultaneous request and response on the same port is legal.
- starve_cnt saturation combined with d_lock_i: lock wins.

Test Plan:
- Fetch only, RD_LATENCY=1: i_req at addr 0x100 in cycle 0 -> i_gnt_o=1, mem_addr_o=0x100, mem_we_o=0 in cycle 0; i_rvalid_o=1, i_rdata_o=mem_rdata_i in cycle 1.
- Contention, STARVE_MAX=4: both req held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; responses arrive in that order.
- Locked RMW: data read at 0x200 with d_lock_i=1 in cycle 0, d_req_i=0 in cycle 1, write 0x200 with be=4'b0001 and d_lock_i=0 in cycle 2, i_req_i held throughout -> no i_gnt_o in cycles 0-2; i_gnt_o in cycle 3; write ack d_rvalid_o=1 with d_rdata_o=0.
- RD_LATENCY=3 pipelined: alternating I/D grants over 6 cycles -> each rvalid exactly 3 cycles after its grant, on the correct port, with no gaps.
- Reset mid-flight: grant data read in cycle 0, assert rst in cycle 1 with RD_LATENCY=2 -> all outputs 0 during reset; no d_rvalid_o after release.
- Idle: no requests for 10 cycles -> mem_req_o=0 and both rvalid outputs 0 throughout; starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data has priority, fetch is forced after a bounded run of data grants, and a tag pipeline routes read responses back to their requester.
module mem_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic        d_lock_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [0:0] LOCK_UNLOCKED = 1'b0;
  localparam logic [0:0] LOCK_LOCKED   = 1'b1;
  localparam logic [3:0] STARVE_LIM    = 4'(STARVE_MAX);

  typedef struct packed {
    logic valid;
    logic is_data;
    logic is_write;
  } tag_t;

  logic [0:0] lock_state;
  logic [0:0] lock_state_next;
  logic [3:0] starve_cnt;
  logic       fetch_forced;
  logic       grant_i;
  logic       grant_d;

  tag_t       tag_pipe [RD_LATENCY];
  tag_t       tag_in;
  tag_t       tag_tail;

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    fetch_forced = i_req_i && d_req_i && (starve_cnt == STARVE_LIM);
    if (!rst) begin
      if (lock_state == LOCK_LOCKED) begin
        grant_d = d_req_i;
      end else if (fetch_forced) begin
        grant_i = 1'b1;
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end else if (i_req_i) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_gnt_o   = grant_i;
  assign d_gnt_o   = grant_d;
  assign mem_req_o = grant_i | grant_d;

  always_comb begin
    lock_state_next = lock_state;
    if (grant_d) begin
      lock_state_next = d_lock_i ? LOCK_LOCKED : LOCK_UNLOCKED;
    end
  end

  // A locked data grant may still count while saturated; the forced fetch simply waits for unlock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LOCK_UNLOCKED;
      starve_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      lock_state <= lock_state_next;
      if (grant_i || !i_req_i) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (grant_d) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (grant_i) begin
      mem_be_o   = 4'hF;
      mem_addr_o = i_addr_i;
    end
  end

  assign tag_in = '{valid: grant_i | grant_d, is_data: grant_d, is_write: grant_d & d_we_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this small tag pipeline is reset because stale valid bits would fire responses after reset.
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_tail   = tag_pipe[RD_LATENCY-1];
  assign i_rvalid_o = tag_tail.valid & ~tag_tail.is_data;
  assign d_rvalid_o = tag_tail.valid &  tag_tail.is_data;
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : 32'h0;
  assign d_rdata_o  = (d_rvalid_o && !tag_tail.is_write) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: three instances (RD_LATENCY 1..3) share stimulus,
// checked each cycle against a behavioural arbitration/response model plus directed scenario checks.
module tb_mem_port_arbiter;

  localparam int N_DUT      = 3;
  localparam int STARVE_MAX = 4;
  localparam int G_NONE = 0, G_I = 1, G_D = 2;
  localparam int T_NONE = 0, T_I = 1, T_DR = 2, T_DW = 3;

  typedef logic [137:0] bundle_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        i_req     = 1'b0;
  logic [31:0] i_addr    = 32'h0;
  logic        d_req     = 1'b0;
  logic        d_we      = 1'b0;
  logic [3:0]  d_be      = 4'h0;
  logic [31:0] d_addr    = 32'h0;
  logic [31:0] d_wdata   = 32'h0;
  logic        d_lock    = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        i_gnt     [N_DUT];
  logic        d_gnt     [N_DUT];
  logic        i_rvalid  [N_DUT];
  logic        d_rvalid  [N_DUT];
  logic        mem_req   [N_DUT];
  logic        mem_we    [N_DUT];
  logic [3:0]  mem_be    [N_DUT];
  logic [31:0] i_rdata   [N_DUT];
  logic [31:0] d_rdata   [N_DUT];
  logic [31:0] mem_addr  [N_DUT];
  logic [31:0] mem_wdata [N_DUT];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: lock flag, starvation run length, per-cycle grant history.
  bit m_locked = 1'b0;
  int m_starve = 0;
  int m_gnt    = G_NONE;
  int cyc      = 0;
  int hist[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_port_arbiter #(.RD_LATENCY(g + 1), .STARVE_MAX(STARVE_MAX)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_req_i    (i_req),
      .i_addr_i   (i_addr),
      .i_gnt_o    (i_gnt[g]),
      .i_rvalid_o (i_rvalid[g]),
      .i_rdata_o  (i_rdata[g]),
      .d_req_i    (d_req),
      .d_we_i     (d_we),
      .d_be_i     (d_be),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_lock_i   (d_lock),
      .d_gnt_o    (d_gnt[g]),
      .d_rvalid_o (d_rvalid[g]),
      .d_rdata_o  (d_rdata[g]),
      .mem_req_o  (mem_req[g]),
      .mem_we_o   (mem_we[g]),
      .mem_be_o   (mem_be[g]),
      .mem_addr_o (mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(mem_rdata)
    );
  end

  function automatic bundle_t observed(int k);
    return {i_gnt[k], d_gnt[k], mem_req[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k],
            i_rvalid[k], i_rdata[k], d_rvalid[k], d_rdata[k]};
  endfunction

  function automatic int model_grant();
    if (rst) return G_NONE;
    if (m_locked) return d_req ? G_D : G_NONE;
    if (i_req && d_req && m_starve == STARVE_MAX) return G_I;
    if (d_req) return G_D;
    if (i_req) return G_I;
    return G_NONE;
  endfunction

  // Expected outputs for the instance with latency k+1: a grant from k+1 cycles ago answers now.
  function automatic bundle_t expected(int k);
    int          t;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    t       = (cyc - (k + 1) >= 0) ? hist[cyc - (k + 1)] : T_NONE;
    e_we    = (m_gnt == G_D) && d_we;
    e_be    = (m_gnt == G_I) ? 4'hF : (m_gnt == G_D) ? d_be : 4'h0;
    e_addr  = (m_gnt == G_I) ? i_addr : (m_gnt == G_D) ? d_addr : 32'h0;
    e_wdata = (m_gnt == G_D) ? d_wdata : 32'h0;
    return {m_gnt == G_I, m_gnt == G_D, m_gnt != G_NONE, e_we, e_be, e_addr, e_wdata,
            t == T_I, (t == T_I) ? mem_rdata : 32'h0,
            t >= T_DR, (t == T_DR) ? mem_rdata : 32'h0};
  endfunction

  // Reset discards any grant whose response has not yet come out.
  task automatic sample();
    if (rst) begin
      for (int j = 1; j <= 4; j++) begin
        if (cyc - j >= 0) hist[cyc - j] = T_NONE;
      end
    end
    m_gnt = model_grant();
    @(negedge clk);
  endtask

  task automatic advance();
    hist.push_back((m_gnt == G_I) ? T_I : (m_gnt == G_D) ? (d_we ? T_DW : T_DR) : T_NONE);
    if (rst) begin
      m_locked = 1'b0;
      m_starve = 0;
    end else begin
      if (m_gnt == G_D) m_locked = d_lock;
      if (m_gnt == G_I || !i_req) m_starve = 0;
      else if (m_gnt == G_D && m_starve < STARVE_MAX) m_starve++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 4; n++) begin
      rst       = (n < 3);
      i_req     = (n < 3);
      d_req     = (n < 3);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_we      = 1'($urandom_range(0, 1));
      d_be      = 4'($urandom);
      mem_rdata = $urandom;
      sample();
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL reset lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
        if (rst) begin
          vectors++;
          if (observed(k) !== '0) begin
            miscompares++;
            $display("FAIL reset_zero lat%0d cyc%0d: got %h want 0", k + 1, cyc, observed(k));
          end
        end
      end
      advance();
    end
  endtask

  task automatic run_idle(input int n_cyc, input string name);
    for (int n = 0; n < n_cyc; n++) begin
      i_req     = 1'b0;
      d_req     = 1'b0;
      d_lock    = 1'b0;
      mem_rdata = $urandom;
      sample();
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL %s lat%0d cyc%0d: got %h want %h", name, k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_fetch_only();
    i_req     = 1'b1;
    i_addr    = 32'h100;
    mem_rdata = $urandom;
    sample();
    vectors++;
    if (i_gnt[0] !== 1'b1 || mem_addr[0] !== 32'h100 || mem_we[0] !== 1'b0 || mem_be[0] !== 4'hF) begin
      miscompares++;
      $display("FAIL fetch_grant: got gnt=%b addr=%h we=%b be=%h want 1 00000100 0 f",
               i_gnt[0], mem_addr[0], mem_we[0], mem_be[0]);
    end
    advance();
    i_req     = 1'b0;
    mem_rdata = $urandom;
    sample();
    vectors++;
    if (i_rvalid[0] !== 1'b1 || i_rdata[0] !== mem_rdata || d_rvalid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_resp: got rvalid=%b rdata=%h d_rvalid=%b want 1 %h 0",
               i_rvalid[0], i_rdata[0], d_rvalid[0], mem_rdata);
    end
    advance();
    run_idle(4, "fetch_drain");
  endtask

  task automatic test_idle();
    for (int n = 0; n < 10; n++) begin
      mem_rdata = $urandom;
      sample();
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (mem_req[k] !== 1'b0 || i_rvalid[k] !== 1'b0 || d_rvalid[k] !== 1'b0 ||
            observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL idle lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    string gseq = "";
    string rseq = "";
    for (int n = 0; n < 12; n++) begin
      i_req = (n < 10);
      d_req = (n < 10);
      d_we  = 1'b0;
      d_lock = 1'b0;
      if (m_gnt == G_I || n == 0) i_addr = 32'h1000 + 32'(n * 4);
      if (m_gnt == G_D || n == 0) d_addr = 32'h2000 + 32'(n * 4);
      mem_rdata = $urandom;
      sample();
      if (n < 10) gseq = {gseq, i_gnt[0] ? "I" : d_gnt[0] ? "D" : "-"};
      if (n >= 1 && n <= 10) rseq = {rseq, i_rvalid[0] ? "I" : d_rvalid[0] ? "D" : "-"};
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL contention lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
    vectors++;
    if (gseq != "DDDDIDDDDI") begin
      miscompares++;
      $display("FAIL contention_grants: got %s want DDDDIDDDDI", gseq);
    end
    vectors++;
    if (rseq != "DDDDIDDDDI") begin
      miscompares++;
      $display("FAIL contention_resps: got %s want DDDDIDDDDI", rseq);
    end
    run_idle(3, "contention_drain");
  endtask

  // Starvation saturates while a lock is taken: the locked follow-up still wins, then fetch.
  task automatic test_lock_vs_starve();
    string gseq = "";
    int    nd   = 0;
    for (int n = 0; n < 6; n++) begin
      i_req  = 1'b1;
      d_req  = 1'b1;
      d_we   = 1'($urandom_range(0, 1));
      d_be   = 4'($urandom);
      d_addr = $urandom;
      d_lock = (nd == 3);
      mem_rdata = $urandom;
      sample();
      gseq = {gseq, i_gnt[0] ? "I" : d_gnt[0] ? "D" : "-"};
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL lock_starve lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      if (m_gnt == G_D) nd++;
      advance();
    end
    vectors++;
    if (gseq != "DDDDDI") begin
      miscompares++;
      $display("FAIL lock_starve_grants: got %s want DDDDDI", gseq);
    end
    run_idle(4, "lock_starve_drain");
  endtask

  task automatic test_locked_rmw();
    for (int r = 0; r < 7; r++) begin
      i_req  = (r <= 3);
      i_addr = 32'h300;
      d_req  = (r == 0 || r == 2);
      d_we   = (r == 2);
      d_be   = (r == 2) ? 4'b0001 : 4'hF;
      d_addr = 32'h200;
      d_wdata = $urandom;
      d_lock = (r == 0);
      mem_rdata = $urandom | 32'h1;
      sample();
      if (r <= 3) begin
        vectors++;
        if (i_gnt[0] !== (r == 3) || d_gnt[0] !== (r == 0 || r == 2)) begin
          miscompares++;
          $display("FAIL rmw_grant r%0d: got i_gnt=%b d_gnt=%b want %b %b",
                   r, i_gnt[0], d_gnt[0], r == 3, r == 0 || r == 2);
        end
      end
      if (r == 2) begin
        vectors++;
        if (mem_we[0] !== 1'b1 || mem_be[0] !== 4'b0001 || mem_addr[0] !== 32'h200) begin
          miscompares++;
          $display("FAIL rmw_write_drive: got we=%b be=%h addr=%h want 1 1 00000200",
                   mem_we[0], mem_be[0], mem_addr[0]);
        end
      end
      for (int k = 0; k < N_DUT; k++) begin
        if (r == 3 + k) begin
          vectors++;
          if (d_rvalid[k] !== 1'b1 || d_rdata[k] !== 32'h0) begin
            miscompares++;
            $display("FAIL rmw_write_ack lat%0d: got rvalid=%b rdata=%h want 1 00000000",
                     k + 1, d_rvalid[k], d_rdata[k]);
          end
        end
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL rmw lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
    run_idle(2, "rmw_drain");
  endtask

  task automatic test_pipelined();
    for (int n = 0; n < 10; n++) begin
      i_req  = (n < 6) && (n % 2 == 0);
      d_req  = (n < 6) && (n % 2 == 1);
      i_addr = $urandom;
      d_addr = $urandom;
      d_we   = 1'($urandom_range(0, 1));
      d_be   = 4'($urandom);
      d_wdata = $urandom;
      d_lock = 1'b0;
      mem_rdata = $urandom;
      sample();
      if (n >= 3 && n <= 8) begin
        vectors++;
        if (i_rvalid[2] !== ((n - 3) % 2 == 0) || d_rvalid[2] !== ((n - 3) % 2 == 1)) begin
          miscompares++;
          $display("FAIL pipe_lat3 n%0d: got i=%b d=%b want %b %b",
                   n, i_rvalid[2], d_rvalid[2], (n - 3) % 2 == 0, (n - 3) % 2 == 1);
        end
      end
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL pipelined lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    for (int n = 0; n < 9; n++) begin
      d_req  = (n == 0);
      d_we   = 1'b0;
      d_addr = 32'h400;
      d_lock = 1'b0;
      i_req  = 1'b0;
      rst    = (n == 1 || n == 2);
      mem_rdata = $urandom;
      sample();
      for (int k = 0; k < N_DUT; k++) begin
        if (rst) begin
          vectors++;
          if (observed(k) !== '0) begin
            miscompares++;
            $display("FAIL midflight_zero lat%0d n%0d: got %h want 0", k + 1, n, observed(k));
          end
        end
        if (n >= 3) begin
          vectors++;
          if (d_rvalid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_rvalid lat%0d n%0d: got %b want 0", k + 1, n, d_rvalid[k]);
          end
        end
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL midflight lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
  endtask

  // Requesters hold each request until the model says it was granted.
  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if (!i_req || m_gnt == G_I) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = $urandom;
      end
      if (!d_req || m_gnt == G_D) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_lock  = ($urandom_range(0, 3) == 0);
      end
      rst       = ($urandom_range(0, 199) == 0);
      mem_rdata = $urandom;
      sample();
      for (int k = 0; k < N_DUT; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("FAIL random lat%0d cyc%0d: got %h want %h", k + 1, cyc, observed(k), expected(k));
        end
      end
      advance();
    end
    rst = 1'b0;
    run_idle(4, "random_drain");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fetch_only();
    test_idle();
    test_contention();
    test_lock_vs_starve();
    test_locked_rmw();
    test_pipelined();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
